// File: rtl/rover_nav_fsm.sv
// Rover travel controller: debounced go request, obstacle-driven turn/reverse
// manoeuvres with fixed durations, saturating odometer and registered wheel commands.
module rover_nav_fsm #(
  parameter int DEBOUNCE       = 2,
  parameter int TURN_CYCLES    = 4,
  parameter int REVERSE_CYCLES = 3,
  parameter int ODO_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             travel_input,
  input  logic [2:0]       obstacle,
  input  logic             dir_pref,
  output logic [2:0]       state,
  output logic [1:0]       motor_l,
  output logic [1:0]       motor_r,
  output logic [ODO_W-1:0] odometer,
  output logic             maneuver_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FWD     = 3'd1,
    TURN_L  = 3'd2,
    TURN_R  = 3'd3,
    REVERSE = 3'd4,
    HALT    = 3'd5
  } state_t;

  localparam logic [3:0]       DEB_LEN   = 4'(DEBOUNCE);
  localparam logic [7:0]       TURN_LAST = 8'(TURN_CYCLES - 1);
  localparam logic [7:0]       REV_LAST  = 8'(REVERSE_CYCLES - 1);
  localparam logic [ODO_W-1:0] ODO_ONE   = ODO_W'(1);

  localparam logic [1:0] M_STOP = 2'b00;
  localparam logic [1:0] M_FWD  = 2'b01;
  localparam logic [1:0] M_REV  = 2'b10;

  state_t           state_reg, state_next;
  logic [7:0]       timer_reg;
  logic             travel_q_reg;
  logic [3:0]       deb_cnt_reg;
  logic [1:0]       motor_l_reg, motor_r_reg;
  logic [1:0]       motor_l_next, motor_r_next;
  logic [ODO_W-1:0] odo_reg;

  logic   left_free, right_free, front_blocked, both_blocked;
  logic   turn_end, rev_end;
  state_t side_turn, pick_state;

  // A new input level must persist DEBOUNCE cycles before travel_q follows it.
  always_ff @(posedge clk) begin
    if (reset) begin
      travel_q_reg <= 1'b0;
      deb_cnt_reg  <= 4'd0;
    end else if (travel_input != travel_q_reg) begin
      if (deb_cnt_reg + 4'd1 == DEB_LEN) begin
        travel_q_reg <= travel_input;
        deb_cnt_reg  <= 4'd0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + 4'd1;
      end
    end else begin
      deb_cnt_reg <= 4'd0;
    end
  end

  assign left_free     = ~obstacle[2];
  assign front_blocked = obstacle[1];
  assign right_free    = ~obstacle[0];
  assign both_blocked  = ~left_free & ~right_free;

  always_comb begin
    side_turn = TURN_R;
    if (left_free && right_free) side_turn = dir_pref ? TURN_R : TURN_L;
    else if (left_free)          side_turn = TURN_L;
    pick_state = both_blocked ? REVERSE : side_turn;
  end

  assign turn_end = (timer_reg == TURN_LAST);
  assign rev_end  = (timer_reg == REV_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (travel_q_reg) state_next = front_blocked ? pick_state : FWD;
      FWD: begin
        // Losing the travel request outranks any obstacle.
        if (!travel_q_reg)      state_next = IDLE;
        else if (front_blocked) state_next = pick_state;
      end
      TURN_L, TURN_R: if (turn_end) state_next = travel_q_reg ? FWD : IDLE;
      REVERSE: if (rev_end) state_next = both_blocked ? HALT : side_turn;
      HALT:    if (!travel_q_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Motors are decoded from the next state so they switch on the same edge as state.
  always_comb begin
    motor_l_next = M_STOP;
    motor_r_next = M_STOP;
    case (state_next)
      FWD:     begin motor_l_next = M_FWD; motor_r_next = M_FWD; end
      TURN_L:  begin motor_l_next = M_REV; motor_r_next = M_FWD; end
      TURN_R:  begin motor_l_next = M_FWD; motor_r_next = M_REV; end
      REVERSE: begin motor_l_next = M_REV; motor_r_next = M_REV; end
      default: begin motor_l_next = M_STOP; motor_r_next = M_STOP; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      timer_reg   <= 8'd0;
      motor_l_reg <= M_STOP;
      motor_r_reg <= M_STOP;
      odo_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= (state_next != state_reg) ? 8'd0 : timer_reg + 8'd1;
      motor_l_reg <= motor_l_next;
      motor_r_reg <= motor_r_next;
      if (state_reg == FWD && odo_reg != '1) odo_reg <= odo_reg + ODO_ONE;
    end
  end

  assign maneuver_done = (((state_reg == TURN_L) || (state_reg == TURN_R)) && turn_end) ||
                         ((state_reg == REVERSE) && rev_end);

  assign state    = state_reg;
  assign motor_l  = motor_l_reg;
  assign motor_r  = motor_r_reg;
  assign odometer = odo_reg;

endmodule
